axis_write_2d: RTL

AXIS_WRITE_2D -- requirements
Module: axis_write_2d

---
 rtl/axis_write_2d.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/axis_write_2d.sv
// ---------------------------------------------------------------------------
// axis_write_2d
//   Turns an incoming data stream into AXI write bursts that cover a 2-D
//   region: `rows` rows of `len` beats each, row r starting at
//   start + r*stride.
//
//   A job is programmed over a small config bus. A word at CFG_ADDR carrying
//   CFG_ID starts the job. Four words at CFG_DATA then follow, in this order:
//   start address (bytes), row length (beats), row stride (bytes), row count.
//
// Handshakes: every channel is valid/ready. A transfer happens on a rising
// clk edge where both valid and ready are high. A source holds valid and its
// payload steady until that edge.
//
// Ports
//   clk, rst                    system clock, synchronous active-high reset
//   cfg_addr/cfg_data/cfg_valid config bus (registered before decode)
//   axi_aw*                     AXI write address channel (master side)
//   axi_w*                      AXI write data channel (master side)
//   data/valid/ready            input stream, passed through to axi_wdata
//   busy                        high while a job is configured or running
//   state_dbg                   one-hot FSM state, for observation only
//
// Build option
//   AXIS_WRITE_2D_BOUNDARY_EN : when defined, bursts are also split so that
//   none crosses a 4 KiB boundary. This assumes the start address and stride
//   are beat-aligned.
// ---------------------------------------------------------------------------
module axis_write_2d #(
  parameter int CFG_ID         = 1,
  parameter int CFG_ADDR       = 23,
  parameter int CFG_DATA       = 24,
  parameter int CFG_AWIDTH     = 5,
  parameter int CFG_DWIDTH     = 32,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int BURST_MAX      = 16,
  parameter int LEN_AWIDTH     = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CFG_AWIDTH-1:0]     cfg_addr,
  input  logic [CFG_DWIDTH-1:0]     cfg_data,
  input  logic                      cfg_valid,
  input  logic                      axi_awready,
  output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
  output logic [AXI_LEN_WIDTH-1:0]  axi_awlen,
  output logic                      axi_awvalid,
  output logic                      axi_wlast,
  output logic [AXI_DATA_WIDTH-1:0] axi_wdata,
  output logic                      axi_wvalid,
  input  logic                      axi_wready,
  input  logic [AXI_DATA_WIDTH-1:0] data,
  input  logic                      valid,
  output logic                      ready,
  output logic                      busy,
  output logic [3:0]                state_dbg
);

  localparam int DEPTH = 1 << LEN_AWIDTH;
  localparam int LOG2B = $clog2(AXI_DATA_WIDTH / 8);
  localparam int BW    = AXI_LEN_WIDTH + 1;  // width of a burst beat count

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_CONFIG = 4'b0010,
    S_ISSUE  = 4'b0100,
    S_DRAIN  = 4'b1000
  } state_t;

  state_t r_state, w_state_next;

  // registered config bus
  logic [CFG_AWIDTH-1:0] r_cfg_addr;
  logic [CFG_DWIDTH-1:0] r_cfg_data;
  logic                  r_cfg_valid;
  logic [1:0]            r_word_idx;

  // job parameters and issue progress
  logic [AXI_ADDR_WIDTH-1:0] r_start, r_stride, r_row_addr, r_cur_addr;
  logic [CFG_DWIDTH-1:0]     r_len, r_beats_left, r_rows_left;
  logic [BW-1:0]             r_cur_beats;  // beats of the burst on the AW bus
  logic [AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic [AXI_LEN_WIDTH-1:0]  r_awlen;
  logic                      r_awvalid;

  // burst-length queue and beat counter
  logic [AXI_LEN_WIDTH-1:0]  r_q [DEPTH];
  logic [LEN_AWIDTH-1:0]     r_wr_ptr, r_rd_ptr;
  logic [LEN_AWIDTH:0]       r_count, w_count_next;
  logic [AXI_LEN_WIDTH-1:0]  r_beat;

  logic                      w_start_hit, w_data_hit, w_last_word, w_zero_job;
  logic                      w_aw_fire, w_final_burst, w_row_end;
  logic                      w_push, w_pop, w_w_fire, w_full, w_nonempty;
  logic [BW-1:0]             w_burst_beats, w_len_m1;
  logic [AXI_ADDR_WIDTH-1:0] w_burst_bytes, w_next_row;

  assign w_start_hit = r_cfg_valid && (r_cfg_addr == CFG_AWIDTH'(CFG_ADDR)) &&
                       (r_cfg_data == CFG_DWIDTH'(CFG_ID));
  assign w_data_hit  = r_cfg_valid && (r_cfg_addr == CFG_AWIDTH'(CFG_DATA));
  assign w_last_word = w_data_hit && (r_word_idx == 2'd3);
  // The row count arrives on the last word itself, so it is tested live.
  assign w_zero_job  = (r_len == '0) || (r_cfg_data == '0);

  assign w_aw_fire     = r_awvalid && axi_awready;
  assign w_row_end     = (r_beats_left == CFG_DWIDTH'(r_cur_beats));
  assign w_final_burst = w_row_end && (r_rows_left == CFG_DWIDTH'(1));
  assign w_burst_bytes = AXI_ADDR_WIDTH'(r_cur_beats) << LOG2B;
  assign w_next_row    = r_row_addr + r_stride;
  assign w_len_m1      = w_burst_beats - BW'(1);

`ifdef AXIS_WRITE_2D_BOUNDARY_EN
  localparam int CW = (BW > 13) ? BW : 13;
  logic [12:0] w_to_4k_bytes, w_to_4k_beats;
  assign w_to_4k_bytes = 13'h1000 - {1'b0, r_cur_addr[11:0]};
  assign w_to_4k_beats = w_to_4k_bytes >> LOG2B;
`endif

  // Burst size: min(BURST_MAX, beats left in the row[, beats left in 4 KiB page])
  always_comb begin
    w_burst_beats = BW'(BURST_MAX);
    if (r_beats_left < CFG_DWIDTH'(BURST_MAX)) w_burst_beats = BW'(r_beats_left);
`ifdef AXIS_WRITE_2D_BOUNDARY_EN
    if (CW'(w_to_4k_beats) < CW'(w_burst_beats)) w_burst_beats = BW'(w_to_4k_beats);
`endif
  end

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // ---- FSM: next state ----
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start_hit) w_state_next = S_CONFIG;
      S_CONFIG: if (w_last_word) w_state_next = w_zero_job ? S_IDLE : S_ISSUE;
      S_ISSUE:  if (w_aw_fire && w_final_burst) w_state_next = S_DRAIN;
      S_DRAIN:  if (w_count_next == '0) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    busy = 1'b0;
    case (r_state)
      S_CONFIG, S_ISSUE, S_DRAIN: busy = 1'b1;
      default:                    busy = 1'b0;
    endcase
  end
  assign state_dbg = r_state;

  // ---- config capture and AW issue ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_addr   <= '0;
      r_cfg_data   <= '0;
      r_cfg_valid  <= 1'b0;
      r_word_idx   <= '0;
      r_start      <= '0;
      r_len        <= '0;
      r_stride     <= '0;
      r_row_addr   <= '0;
      r_cur_addr   <= '0;
      r_beats_left <= '0;
      r_rows_left  <= '0;
      r_cur_beats  <= '0;
      r_awaddr     <= '0;
      r_awlen      <= '0;
      r_awvalid    <= 1'b0;
    end else begin
      r_cfg_addr  <= cfg_addr;
      r_cfg_data  <= cfg_data;
      r_cfg_valid <= cfg_valid;

      if (r_state == S_IDLE) r_word_idx <= '0;
      if (r_state == S_CONFIG && w_data_hit) begin
        r_word_idx <= r_word_idx + 2'd1;
        case (r_word_idx)
          2'd0: r_start  <= AXI_ADDR_WIDTH'(r_cfg_data);
          2'd1: r_len    <= r_cfg_data;
          2'd2: r_stride <= AXI_ADDR_WIDTH'(r_cfg_data);
          default: begin
            r_row_addr   <= r_start;
            r_cur_addr   <= r_start;
            r_beats_left <= r_len;
            r_rows_left  <= r_cfg_data;
          end
        endcase
      end

      // Address and length are loaded only while awvalid is low, so they
      // stay stable for the whole time the burst waits for awready.
      if (w_aw_fire) begin
        r_awvalid <= 1'b0;
        if (w_row_end) begin
          r_rows_left  <= r_rows_left - CFG_DWIDTH'(1);
          r_row_addr   <= w_next_row;
          r_cur_addr   <= w_next_row;
          r_beats_left <= r_len;
        end else begin
          r_beats_left <= r_beats_left - CFG_DWIDTH'(r_cur_beats);
          r_cur_addr   <= r_cur_addr + w_burst_bytes;
        end
      end else if (r_state == S_ISSUE && !r_awvalid && !w_full) begin
        r_awvalid   <= 1'b1;
        r_awaddr    <= r_cur_addr;
        r_awlen     <= w_len_m1[AXI_LEN_WIDTH-1:0];
        r_cur_beats <= w_burst_beats;
      end
    end
  end

  assign axi_awaddr  = r_awaddr;
  assign axi_awlen   = r_awlen;
  assign axi_awvalid = r_awvalid;

  // ---- burst-length queue: one entry per accepted AW burst ----
  assign w_nonempty = (r_count != '0);
  assign w_full     = (r_count == (LEN_AWIDTH + 1)'(DEPTH));
  assign w_push     = w_aw_fire;
  assign w_w_fire   = axi_wvalid && axi_wready;
  assign w_pop      = w_w_fire && axi_wlast;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_q[r_wr_ptr] <= r_awlen;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_beat   <= '0;
    end else begin
      r_count <= w_count_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_w_fire) r_beat <= axi_wlast ? '0 : r_beat + 1'b1;
    end
  end

  // The data path is a pass-through gated by "a burst has been granted".
  assign axi_wdata  = data;
  assign axi_wvalid = valid && w_nonempty;
  assign ready      = axi_wready && w_nonempty;
  assign axi_wlast  = w_nonempty && (r_beat == r_q[r_rd_ptr]);

endmodule
